mips_dmem_resp: RTL and testbench

Data-memory responder for the MIPS core's data port: it sits on the far side of `memwrite`/`aluout`/`writedata`/`readdata`. It serves a word-addressed RAM and a small memory-mapped I/O page containing a GPIO port, a free-running cycle counter and a down-counting timer with interrupt. Reads are combinational, as the single-cycle core requires. Writes, counters and the timer FSM are clocked.

---
 rtl/mips_mmio_pkg.sv | 20 ++
 rtl/mmio_timer.sv | 88 ++++++++
 rtl/mips_dmem_resp.sv | 106 ++++++++++
 tb/tb_mips_dmem_resp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared constants and types for the MIPS data-memory responder and its MMIO page.
package mips_mmio_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hFFFF;

  localparam logic [7:0] OFF_GPIO_OUT   = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN    = 8'h04;
  localparam logic [7:0] OFF_CYCLE      = 8'h08;
  localparam logic [7:0] OFF_TIMER_CNT  = 8'h0C;
  localparam logic [7:0] OFF_TIMER_CTRL = 8'h10;
  localparam logic [7:0] OFF_TIMER_LOAD = 8'h14;
  localparam logic [7:0] OFF_STATUS     = 8'h18;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_PEND = 2;

  typedef enum logic {T_IDLE, T_RUN} timer_state_t;

endpackage

// File: rtl/mmio_timer.sv
// Down-counting MMIO timer: CNT/LOAD/CTRL registers, IDLE/RUN FSM and the
// write-1-to-clear pending flag.
module mmio_timer
  import mips_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_cnt,
  input  logic        we_ctrl,
  input  logic        we_load,
  input  logic [31:0] writedata,
  output logic [31:0] cnt,
  output logic [31:0] load,
  output logic [2:0]  ctrl,
  output logic        pend
);

  timer_state_t state, state_n;
  logic         en, en_n, autorl, autorl_n, pend_n;
  logic [31:0]  cnt_n, load_n;
  logic         stop, run_ok;

  // A CTRL store with EN=0 halts the count in the same cycle.
  assign stop   = we_ctrl && !writedata[CTRL_EN];
  assign run_ok = en && !stop;
  assign ctrl   = {pend, autorl, en};

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load_n   = load;
    en_n     = en;
    autorl_n = autorl;
    pend_n   = pend;

    if (we_load) load_n = writedata;
    if (we_ctrl) begin
      en_n     = writedata[CTRL_EN];
      autorl_n = writedata[CTRL_AUTO];
      if (writedata[CTRL_PEND]) pend_n = 1'b0;
    end

    case (state)
      T_IDLE: if (run_ok && cnt != '0) state_n = T_RUN;
      T_RUN: begin
        if (!run_ok) begin
          state_n = T_IDLE;
        end else if (cnt == 32'd1) begin
          // Expiry is applied after the W1C so a same-cycle clear loses.
          cnt_n  = '0;
          pend_n = 1'b1;
          if (!autorl) begin
            en_n    = 1'b0;
            state_n = T_IDLE;
          end
        end else if (cnt == '0) begin
          if (autorl && load != '0) cnt_n = load;
          else state_n = T_IDLE;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
    endcase

    if (we_cnt) cnt_n = writedata;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= T_IDLE;
      cnt    <= '0;
      load   <= '0;
      en     <= 1'b0;
      autorl <= 1'b0;
      pend   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      load   <= load_n;
      en     <= en_n;
      autorl <= autorl_n;
      pend   <= pend_n;
    end
  end

endmodule

// File: rtl/mips_dmem_resp.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO page
// with GPIO, a free-running cycle counter and a down-counting timer.
module mips_dmem_resp
  import mips_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic           is_mmio, misalign, wr_ok, wr_mmio, ram_we;
  logic [7:0]     off;
  logic [AW-1:0]  ram_idx;
  logic [31:0]    ram [RAM_WORDS];
  logic [31:0]    ram_rdata, cycle, t_cnt, t_load;
  logic [2:0]     t_ctrl;
  logic [7:0]     sync1, sync2;
  logic           status, t_pend;
  logic           we_gpio, we_cnt, we_ctrl, we_load, we_status;
  logic           unused_addr;

  assign is_mmio  = aluout[31:16] == MMIO_BASE;
  assign misalign = aluout[1:0] != 2'b00;
  // Misaligned accesses read the word at the truncated address.
  assign off      = {aluout[7:2], 2'b00};
  assign ram_idx  = aluout[AW+1:2];
  assign unused_addr = ^aluout[15:8];

  assign wr_ok     = memwrite && !misalign;
  assign wr_mmio   = wr_ok && is_mmio;
  assign ram_we    = wr_ok && !is_mmio;
  assign we_gpio   = wr_mmio && off == OFF_GPIO_OUT;
  assign we_cnt    = wr_mmio && off == OFF_TIMER_CNT;
  assign we_ctrl   = wr_mmio && off == OFF_TIMER_CTRL;
  assign we_load   = wr_mmio && off == OFF_TIMER_LOAD;
  assign we_status = wr_mmio && off == OFF_STATUS;

  // NOTE: the RAM array has no reset; software must write a word before relying on it.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= writedata;
  end
  assign ram_rdata = ram[ram_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
      cycle    <= '0;
      status   <= 1'b0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      cycle <= cycle + 32'd1;
      if (we_gpio) gpio_out <= writedata[7:0];
      // A misaligned store sets MISALIGN with priority over its clear.
      if (memwrite && misalign) status <= 1'b1;
      else if (we_status && writedata[0]) status <= 1'b0;
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .we_cnt    (we_cnt),
    .we_ctrl   (we_ctrl),
    .we_load   (we_load),
    .writedata (writedata),
    .cnt       (t_cnt),
    .load      (t_load),
    .ctrl      (t_ctrl),
    .pend      (t_pend)
  );

  assign timer_irq = t_pend;

  always_comb begin
    readdata = '0;
    if (is_mmio) begin
      case (off)
        OFF_GPIO_OUT:   readdata = {24'b0, gpio_out};
        OFF_GPIO_IN:    readdata = {24'b0, sync2};
        OFF_CYCLE:      readdata = cycle;
        OFF_TIMER_CNT:  readdata = t_cnt;
        OFF_TIMER_CTRL: readdata = {29'b0, t_ctrl};
        OFF_TIMER_LOAD: readdata = t_load;
        OFF_STATUS:     readdata = {31'b0, status};
        default:        readdata = '0;
      endcase
    end else begin
      readdata = ram_rdata;
    end
  end

endmodule

// File: tb/tb_mips_dmem_resp.sv
// Directed plus randomized bench for mips_dmem_resp against a behavioural model
// of the RAM, MMIO registers and timer.
module tb_mips_dmem_resp;
  import mips_mmio_pkg::*;

  localparam int          RW = 64;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset, memwrite, timer_irq;
  logic [31:0] aluout, writedata, readdata;
  logic [7:0]  gpio_in, gpio_out;

  int n_cmp = 0;
  int n_err = 0;

  mips_dmem_resp #(.RAM_WORDS(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_ram [RW];
  bit          m_ram_ok [RW];
  logic [7:0]  m_gpio, m_h1, m_h2;
  logic [31:0] m_cycle, m_cnt, m_load;
  bit          m_en, m_auto, m_pend, m_status, m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit          mis, mmio, wr, wcnt, wctrl, wload, halt;
    logic [7:0]  o;
    logic [31:0] n_cnt, n_load;
    bit          n_en, n_auto, n_pend, n_run;
    mis  = aluout[1:0] != 2'b00;
    mmio = aluout[31:16] == 16'hFFFF;
    o    = {aluout[7:2], 2'b00};
    wr   = memwrite && !mis;
    if (wr && !mmio) begin
      m_ram[aluout[7:2]]    = writedata;
      m_ram_ok[aluout[7:2]] = 1'b1;
    end
    if (!reset) begin
      m_gpio = 0; m_h1 = 0; m_h2 = 0; m_cycle = 0; m_status = 0;
      m_cnt = 0; m_load = 0; m_en = 0; m_auto = 0; m_pend = 0; m_run = 0;
      return;
    end
    wcnt  = wr && mmio && o == 8'h0C;
    wctrl = wr && mmio && o == 8'h10;
    wload = wr && mmio && o == 8'h14;
    halt  = wctrl && !writedata[0];
    n_cnt = m_cnt; n_load = m_load; n_en = m_en; n_auto = m_auto; n_pend = m_pend; n_run = m_run;
    if (wload) n_load = writedata;
    if (wctrl) begin
      n_en = writedata[0]; n_auto = writedata[1];
      if (writedata[2]) n_pend = 0;
    end
    if (!m_run) begin
      if (m_en && !halt && m_cnt != 0) n_run = 1;
    end else if (!m_en || halt) begin
      n_run = 0;
    end else if (m_cnt == 1) begin
      n_cnt = 0; n_pend = 1;
      if (!m_auto) begin n_en = 0; n_run = 0; end
    end else if (m_cnt == 0) begin
      if (m_auto && m_load != 0) n_cnt = m_load;
      else n_run = 0;
    end else begin
      n_cnt = m_cnt - 1;
    end
    if (wcnt) n_cnt = writedata;
    if (memwrite && mis) m_status = 1;
    else if (wr && mmio && o == 8'h18 && writedata[0]) m_status = 0;
    if (wr && mmio && o == 8'h00) m_gpio = writedata[7:0];
    m_h2 = m_h1; m_h1 = gpio_in;
    m_cycle = m_cycle + 1;
    m_cnt = n_cnt; m_load = n_load; m_en = n_en; m_auto = n_auto; m_pend = n_pend; m_run = n_run;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit ok);
    logic [7:0] o;
    ok = 1'b1;
    o  = {a[7:2], 2'b00};
    if (a[31:16] != 16'hFFFF) begin
      ok = m_ram_ok[a[7:2]];
      return m_ram[a[7:2]];
    end
    case (o)
      8'h00:   return {24'b0, m_gpio};
      8'h04:   return {24'b0, m_h2};
      8'h08:   return m_cycle;
      8'h0C:   return m_cnt;
      8'h10:   return {29'b0, m_pend, m_auto, m_en};
      8'h14:   return m_load;
      8'h18:   return {31'b0, m_status};
      default: return 32'b0;
    endcase
  endfunction

  task automatic cyc(input bit mw, input logic [31:0] a, input logic [31:0] wd);
    memwrite = mw; aluout = a; writedata = wd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0; aluout = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok, mw;
    int          sel;
    logic [31:0] a, wd, exp;

    for (int i = 0; i < RW; i++) m_ram_ok[i] = 1'b0;
    reset = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0; gpio_in = '0;
    @(negedge clk);
    cyc(0, 0, 0);
    cyc(1, MB, 32'hFF);
    check("rst_gpio_out", {24'b0, gpio_out}, 0);
    check("rst_irq", {31'b0, timer_irq}, 0);
    rd("rst_cycle", MB | 32'h08, 0);
    rd("rst_ctrl", MB | 32'h10, 0);
    rd("rst_status", MB | 32'h18, 0);
    reset = 1'b1;

    // RAM store/load and aliasing
    cyc(1, 32'h40, 32'hDEADBEEF);
    rd("ram_rd", 32'h40, 32'hDEADBEEF);
    rd("ram_alias", 32'h40 + 4 * RW, 32'hDEADBEEF);

    // Misaligned store is dropped and flagged
    cyc(1, 32'h42, 32'h12345678);
    rd("mis_nowrite", 32'h40, 32'hDEADBEEF);
    rd("mis_trunc_rd", 32'h43, 32'hDEADBEEF);
    rd("status_set", MB | 32'h18, 1);
    cyc(1, MB | 32'h18, 1);
    rd("status_clr", MB | 32'h18, 0);

    // GPIO
    cyc(1, MB, 32'h1A5);
    check("gpio_out", {24'b0, gpio_out}, 32'hA5);
    rd("gpio_out_rd", MB, 32'hA5);
    gpio_in = 8'h3C;
    cyc(0, 0, 0);
    rd("gpio_in_1cyc", MB | 32'h04, 0);
    cyc(0, 0, 0);
    rd("gpio_in_2cyc", MB | 32'h04, 32'h3C);

    // CYCLE back-to-back
    rd("cycle_a", MB | 32'h08, m_cycle);
    exp = m_cycle + 1;
    cyc(0, MB | 32'h08, 0);
    rd("cycle_b", MB | 32'h08, exp);

    // One-shot timer
    cyc(1, MB | 32'h0C, 5);
    cyc(1, MB | 32'h10, 1);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, 0);
      check($sformatf("oneshot_irq_%0d", k), {31'b0, timer_irq}, (k == 6) ? 32'd1 : 32'd0);
    end
    rd("oneshot_ctrl", MB | 32'h10, 32'h4);
    check("oneshot_idle", {31'b0, dut.u_timer.state}, {31'b0, T_IDLE});
    cyc(1, MB | 32'h10, 4);
    check("w1c_irq", {31'b0, timer_irq}, 0);

    // Auto-reload, W1C-vs-expiry and CNT write priority
    cyc(1, MB | 32'h14, 3);
    cyc(1, MB | 32'h0C, 3);
    cyc(1, MB | 32'h10, 3);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 0);
    check("auto_exp1_irq", {31'b0, timer_irq}, 1);
    rd("auto_exp1_cnt", MB | 32'h0C, 0);
    cyc(1, MB | 32'h10, 7);
    check("auto_w1c_irq", {31'b0, timer_irq}, 0);
    rd("auto_reload_cnt", MB | 32'h0C, 3);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, MB | 32'h10, 7);
    check("w1c_on_expiry", {31'b0, timer_irq}, 1);
    cyc(1, MB | 32'h0C, 100);
    rd("cnt_override", MB | 32'h0C, 100);
    cyc(0, 0, 0);
    rd("cnt_dec_after", MB | 32'h0C, 99);
    cyc(1, MB | 32'h10, 4);
    check("stop_idle", {31'b0, dut.u_timer.state}, {31'b0, T_IDLE});
    check("stop_irq", {31'b0, timer_irq}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel     = $urandom_range(0, 9);
      gpio_in = 8'($urandom);
      reset   = ($urandom_range(0, 60) != 0);
      wd      = $urandom;
      mw      = ($urandom_range(0, 1) == 1);
      case (sel)
        0, 1:    a = $urandom & 32'h0000_03FC;
        2:       a = ($urandom & 32'h0000_03FF) | 32'h1;
        3:       a = MB | {16'b0, 8'($urandom), 8'($urandom_range(0, 7) * 4 + 2)};
        default: a = MB | {16'b0, 8'($urandom), 8'($urandom_range(0, 8) * 4)};
      endcase
      if (a[31:16] == 16'hFFFF && a[7:0] == 8'h0C) wd = $urandom_range(0, 6);
      if (a[31:16] == 16'hFFFF && a[7:0] == 8'h14) wd = $urandom_range(0, 5);
      if (a[31:16] == 16'hFFFF && a[7:0] == 8'h10) wd = $urandom_range(0, 7);
      memwrite = mw; aluout = a; writedata = wd;
      #1;
      if (!mw) begin
        exp = model_read(a, ok);
        if (ok) check("rnd_read", readdata, exp);
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rnd_gpio_out", {24'b0, gpio_out}, {24'b0, m_gpio});
      check("rnd_irq", {31'b0, timer_irq}, {31'b0, m_pend});
    end
    memwrite = 1'b0;
    reset = 1'b1;

    // Reset in the middle of a running count with CYCLE at 0x123
    reset = 1'b0;
    cyc(0, 0, 0);
    reset = 1'b1;
    cyc(1, MB | 32'h0C, 1000);
    cyc(1, MB | 32'h10, 1);
    for (int k = 0; k < 400 && m_cycle != 32'h123; k++) cyc(0, 0, 0);
    rd("cycle_123", MB | 32'h08, 32'h123);
    check("running_before_rst", {31'b0, dut.u_timer.state}, {31'b0, T_RUN});
    reset = 1'b0;
    cyc(1, MB, 32'h5A);
    reset = 1'b1;
    check("midrst_gpio_out", {24'b0, gpio_out}, 0);
    check("midrst_irq", {31'b0, timer_irq}, 0);
    check("midrst_idle", {31'b0, dut.u_timer.state}, {31'b0, T_IDLE});
    rd("midrst_cycle", MB | 32'h08, 0);
    rd("midrst_cnt", MB | 32'h0C, 0);
    rd("midrst_ctrl", MB | 32'h10, 0);
    rd("midrst_load", MB | 32'h14, 0);
    rd("midrst_gpio_in", MB | 32'h04, 0);

    // CYCLE wrap from all-ones
    force dut.cycle = 32'hFFFF_FFFF;
    rd("cycle_max", MB | 32'h08, 32'hFFFF_FFFF);
    release dut.cycle;
    m_cycle = 32'hFFFF_FFFF;
    cyc(0, MB | 32'h08, 0);
    rd("cycle_wrap", MB | 32'h08, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
